// File: rtl/rect_pulse_meter_pkg.sv
// Shared types for rect_pulse_meter: FSM state, measurement record and the
// saturating counter helpers.
package rect_pulse_meter_pkg;

  localparam int unsigned CNT_W_MAX = 32;

  typedef logic [CNT_W_MAX-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    HIGH,
    LOW
  } state_t;

  typedef struct packed {
    cnt_t               td;
    cnt_t               th;
    cnt_t               tl;
    logic [CNT_W_MAX:0] period;
    logic               sat;
  } meas_rec_t;

  // All-ones value of a w-bit counter held in a cnt_t.
  function automatic cnt_t cnt_max(input int unsigned w);
    cnt_t m;
    m = '0;
    for (int unsigned i = 0; i < CNT_W_MAX; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic cnt_t sat_inc(input cnt_t v, input int unsigned w);
    return (v == cnt_max(w)) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/rect_edge_sync.sv
// Synchronizer for sig_in, optional glitch filter (RECT_PULSE_METER_GLITCH_FILTER_EN),
// and single-cycle rise/fall strobes of the cleaned level.
module rect_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
`ifdef RECT_PULSE_METER_GLITCH_FILTER_EN
  , parameter int unsigned FILT_LEN  = 3
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d1_q;

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
  end

`ifdef RECT_PULSE_METER_GLITCH_FILTER_EN
  localparam int unsigned FW = $clog2(FILT_LEN + 1);

  logic [FW-1:0] fcnt_q;
  logic          filt_q;

  // Level only follows the synchronizer after FILT_LEN consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
      fcnt_q <= '0;
    end else if (fcnt_q == FW'(FILT_LEN - 1)) begin
      filt_q <= sync_q[SYNC_STAGES-1];
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + FW'(1);
    end
  end

  assign s = filt_q;
`else
  assign s = sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) s_d1_q <= 1'b0;
    else        s_d1_q <= s;
  end

  assign rise = s & ~s_d1_q;
  assign fall = ~s & s_d1_q;

endmodule

// File: rtl/rect_pulse_meter.sv
// Pulse-train meter: delay to first rise, high/low time and period in clk cycles,
// delivered over valid/ready. Optional glitch filter: RECT_PULSE_METER_GLITCH_FILTER_EN.
module rect_pulse_meter
  import rect_pulse_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] td_cyc,
  output logic [CNT_W-1:0] th_cyc,
  output logic [CNT_W-1:0] tl_cyc,
  output logic [CNT_W:0]   period_cyc,
  output logic             sat,
  output logic             overrun,
  output logic             busy
);

  localparam cnt_t MAX = cnt_max(CNT_W);

  logic      rise, fall;
  state_t    state_q, state_d;
  cnt_t      td_q, td_d, th_q, th_d, tl_q, tl_d;
  logic      sat_q, sat_d;
  logic      cap;
  meas_rec_t cap_rec, rec_q;
  logic      valid_q, ovr_q;

  rect_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
`ifdef RECT_PULSE_METER_GLITCH_FILTER_EN
    , .FILT_LEN(FILT_LEN)
`endif
  ) u_edge_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .sig_in(sig_in),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      td_q    <= '0;
      th_q    <= '0;
      tl_q    <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      td_q    <= td_d;
      th_q    <= th_d;
      tl_q    <= tl_d;
      sat_q   <= sat_d;
    end
  end

  // The edge cycle itself counts toward the new phase, so a rise/fall loads 1.
  always_comb begin
    state_d = state_q;
    td_d    = td_q;
    th_d    = th_q;
    tl_d    = tl_q;
    sat_d   = sat_q;
    cap     = 1'b0;
    if (!en) begin
      state_d = IDLE;
      td_d    = '0;
      th_d    = '0;
      tl_d    = '0;
      sat_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = WAIT_RISE;
          td_d    = '0;
          th_d    = '0;
          tl_d    = '0;
          sat_d   = 1'b0;
        end
        WAIT_RISE: begin
          if (rise) begin
            state_d = HIGH;
            th_d    = cnt_t'(1);
          end else begin
            td_d  = sat_inc(td_q, CNT_W);
            sat_d = sat_q | (td_q == MAX);
          end
        end
        HIGH: begin
          if (fall) begin
            state_d = LOW;
            tl_d    = cnt_t'(1);
          end else begin
            th_d  = sat_inc(th_q, CNT_W);
            sat_d = sat_q | (th_q == MAX);
          end
        end
        LOW: begin
          if (rise) begin
            cap     = 1'b1;
            state_d = HIGH;
            td_d    = '0;
            th_d    = cnt_t'(1);
            tl_d    = '0;
            sat_d   = 1'b0;
          end else begin
            tl_d  = sat_inc(tl_q, CNT_W);
            sat_d = sat_q | (tl_q == MAX);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign cap_rec = '{td:     td_q,
                     th:     th_q,
                     tl:     tl_q,
                     period: {1'b0, th_q} + {1'b0, tl_q},
                     sat:    sat_q};

  // A transfer in the capture cycle frees the slot, so back-to-back records are kept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rec_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (valid_q && meas_ready)  ovr_q <= 1'b0;
      else if (cap && valid_q)    ovr_q <= 1'b1;
      if (cap && (!valid_q || meas_ready)) begin
        rec_q   <= cap_rec;
        valid_q <= 1'b1;
      end else if (valid_q && meas_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign meas_valid = valid_q;
  assign td_cyc     = CNT_W'(rec_q.td);
  assign th_cyc     = CNT_W'(rec_q.th);
  assign tl_cyc     = CNT_W'(rec_q.tl);
  assign period_cyc = (CNT_W + 1)'(rec_q.period);
  assign sat        = rec_q.sat;
  assign overrun    = ovr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_rect_pulse_meter.sv
// Scoreboard bench for rect_pulse_meter: a 16-bit instance for the main scenarios
// and a 4-bit instance for saturation.
module tb_rect_pulse_meter;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned FILT_LEN    = 3;
`ifdef RECT_PULSE_METER_GLITCH_FILTER_EN
  localparam int unsigned LAT     = SYNC_STAGES - 1 + FILT_LEN;
  localparam int unsigned TH_MIN  = FILT_LEN;
  localparam int unsigned SAT_LOW = FILT_LEN;
`else
  localparam int unsigned LAT     = SYNC_STAGES - 1;
  localparam int unsigned TH_MIN  = 1;
  localparam int unsigned SAT_LOW = 2;
`endif

  typedef struct {
    int unsigned td;
    int unsigned th;
    int unsigned tl;
    int unsigned period;
    bit          sat;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_en, a_sig, a_ready, a_valid, a_sat, a_ovr, a_busy;
  logic [15:0] a_td, a_th, a_tl;
  logic [16:0] a_period;
  logic        b_en, b_sig, b_ready, b_valid, b_sat, b_ovr, b_busy;
  logic [3:0]  b_td, b_th, b_tl;
  logic [4:0]  b_period;

  rect_pulse_meter #(.CNT_W(16), .SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(a_en), .sig_in(a_sig),
    .meas_valid(a_valid), .meas_ready(a_ready),
    .td_cyc(a_td), .th_cyc(a_th), .tl_cyc(a_tl), .period_cyc(a_period),
    .sat(a_sat), .overrun(a_ovr), .busy(a_busy)
  );

  rect_pulse_meter #(.CNT_W(4), .SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(b_en), .sig_in(b_sig),
    .meas_valid(b_valid), .meas_ready(b_ready),
    .td_cyc(b_td), .th_cyc(b_th), .tl_cyc(b_tl), .period_cyc(b_period),
    .sat(b_sat), .overrun(b_ovr), .busy(b_busy)
  );

  int   checks = 0;
  int   errors = 0;
  rec_t q_a[$];
  rec_t q_b[$];

  function automatic rec_t mk(int unsigned td, int unsigned th, int unsigned tl,
                              int unsigned p, bit s);
    rec_t r;
    r.td = td; r.th = th; r.tl = tl; r.period = p; r.sat = s;
    return r;
  endfunction

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endfunction

  function automatic void chk_rec(string nm, rec_t a, rec_t e);
    checks++;
    if (a.td != e.td || a.th != e.th || a.tl != e.tl || a.period != e.period || a.sat != e.sat) begin
      errors++;
      $display("FAIL %s actual td=%0d th=%0d tl=%0d period=%0d sat=%0d required td=%0d th=%0d tl=%0d period=%0d sat=%0d",
               nm, a.td, a.th, a.tl, a.period, a.sat, e.td, e.th, e.tl, e.period, e.sat);
    end
  endfunction

  function automatic void chk_a_cleared(string nm);
    chk({nm, "_flags"}, 64'({a_valid, a_sat, a_ovr, a_busy}), 64'd0);
    chk({nm, "_counts"}, 64'({a_td, a_th, a_tl}), 64'd0);
    chk({nm, "_period"}, 64'(a_period), 64'd0);
  endfunction

  // Monitors: a record is consumed whenever valid && ready is seen before the edge.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && a_valid && a_ready) begin
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_record_a actual td=%0d th=%0d tl=%0d required none", a_td, a_th, a_tl);
      end else begin
        chk_rec("record_a", mk(32'(a_td), 32'(a_th), 32'(a_tl), 32'(a_period), a_sat), q_a.pop_front());
      end
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (rst_n && b_valid && b_ready) begin
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_record_b actual td=%0d th=%0d tl=%0d required none", b_td, b_th, b_tl);
      end else begin
        chk_rec("record_b", mk(32'(b_td), 32'(b_th), 32'(b_tl), 32'(b_period), b_sat), q_b.pop_front());
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    a_en = 1'b0; a_sig = 1'b0; a_ready = 1'b0;
    b_en = 1'b0; b_sig = 1'b0; b_ready = 1'b0;
    tick(3);
    chk_a_cleared("reset_a");
    chk("reset_b_flags", 64'({b_valid, b_sat, b_ovr, b_busy, b_td, b_th, b_tl, b_period}), 64'd0);
    rst_n = 1'b1;
    tick(2);

    // Clean train: first record carries td, later ones td=0.
    a_ready = 1'b1;
    a_en    = 1'b1;
    q_a.push_back(mk(10 + LAT, 5, 3, 8, 1'b0));
    q_a.push_back(mk(0, 5, 3, 8, 1'b0));
    q_a.push_back(mk(0, 5, 3, 8, 1'b0));
    tick(10);
    for (int i = 0; i < 3; i++) begin
      a_sig = 1'b1; tick(5);
      a_sig = 1'b0; tick(3);
    end
    a_sig = 1'b1; tick(6);
    chk("train_busy", 64'(a_busy), 64'd1);
    a_en = 1'b0; tick(2);
    chk("train_idle", 64'(a_busy), 64'd0);
    a_sig = 1'b0; tick(10);

    // Backpressure: first record held, second dropped with overrun.
    a_ready = 1'b0;
    a_en    = 1'b1;
    q_a.push_back(mk(4 + LAT, 4, 3, 7, 1'b0));
    tick(4);
    a_sig = 1'b1; tick(4); a_sig = 1'b0; tick(3);
    a_sig = 1'b1; tick(4); a_sig = 1'b0; tick(3);
    a_sig = 1'b1; tick(8);
    chk("bp_overrun_set", 64'(a_ovr), 64'd1);
    chk("bp_valid_held", 64'(a_valid), 64'd1);
    chk("bp_td_held", 64'(a_td), 64'(4 + LAT));
    chk("bp_th_held", 64'(a_th), 64'd4);
    chk("bp_tl_held", 64'(a_tl), 64'd3);
    a_ready = 1'b1; tick(1);
    chk("bp_valid_drop", 64'(a_valid), 64'd0);
    chk("bp_overrun_clr", 64'(a_ovr), 64'd0);
    a_en = 1'b0; tick(1);
    a_sig = 1'b0; tick(10);

    // en drop mid-HIGH, then re-enable with a minimum-width high pulse.
    a_en = 1'b1; tick(5);
    a_sig = 1'b1; tick(8);
    chk("endrop_busy_before", 64'(a_busy), 64'd1);
    a_en = 1'b0; tick(1);
    chk("endrop_busy_after", 64'(a_busy), 64'd0);
    chk("endrop_no_record", 64'(a_valid), 64'd0);
    a_sig = 1'b0; tick(10);
    a_en = 1'b1;
    q_a.push_back(mk(7 + LAT, TH_MIN, 4, TH_MIN + 4, 1'b0));
    tick(7);
    a_sig = 1'b1; tick(TH_MIN);
    a_sig = 1'b0; tick(4);
    a_sig = 1'b1; tick(8);
    a_en = 1'b0; a_sig = 1'b0; tick(10);

    // Reset mid-LOW with an unaccepted record pending.
    a_ready = 1'b0;
    a_en    = 1'b1; tick(4);
    a_sig = 1'b1; tick(3); a_sig = 1'b0; tick(3);
    a_sig = 1'b1; tick(8); a_sig = 1'b0; tick(8);
    chk("rst_pending_valid", 64'(a_valid), 64'd1);
    rst_n = 1'b0; a_en = 1'b0; tick(1);
    chk_a_cleared("rst_mid");
    rst_n = 1'b1; a_ready = 1'b1; tick(5);
    chk("rst_no_stale", 64'(a_valid), 64'd0);

    // Saturation on the 4-bit instance.
    b_ready = 1'b1;
    b_en    = 1'b1;
    q_b.push_back(mk(2 + LAT, 15, SAT_LOW, 15 + SAT_LOW, 1'b1));
    tick(2);
    b_sig = 1'b1; tick(20);
    b_sig = 1'b0; tick(SAT_LOW);
    b_sig = 1'b1; tick(8);
    b_en = 1'b0; b_sig = 1'b0; tick(10);

`ifdef RECT_PULSE_METER_GLITCH_FILTER_EN
    // Short glitch is swallowed; a FILT_LEN-wide pulse is measured.
    a_en = 1'b1;
    q_a.push_back(mk(12 + LAT, FILT_LEN, 5, FILT_LEN + 5, 1'b0));
    tick(4);
    a_sig = 1'b1; tick(FILT_LEN - 1);
    a_sig = 1'b0; tick(6 - (FILT_LEN - 1) + 2);
    chk("glitch_no_record", 64'({a_valid, a_busy}), 64'd1);
    a_sig = 1'b1; tick(FILT_LEN);
    a_sig = 1'b0; tick(5);
    a_sig = 1'b1; tick(8);
    a_en = 1'b0; a_sig = 1'b0; tick(10);
`endif

    chk("queue_a_drained", 64'(q_a.size()), 64'd0);
    chk("queue_b_drained", 64'(q_b.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
